// File: rtl/seq_multiplier_param_if.sv
// seq_multiplier_param_if
//   Handshake and operand bundle for the shift-add multiplier seq_multiplier_param.
//
//   Signals:
//     startMul  start request, level-sampled by the multiplier on rising clk
//     A         multiplier operand (WIDTH bits), sampled on an accepted start
//     B         multiplicand operand (WIDTH bits), sampled on an accepted start
//     product   full 2*WIDTH-bit product, registered, held until the next result
//     busy      high while iterations are in progress
//     doneMul   one-cycle completion pulse
//
//   Modports:
//     master  requester side: drives startMul/A/B, observes product/busy/doneMul
//     slave   multiplier side
interface seq_multiplier_param_if #(
  parameter int unsigned WIDTH = 24
) ();

  logic                 startMul;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 doneMul;

  modport master (
    output startMul,
    output A,
    output B,
    input  product,
    input  busy,
    input  doneMul
  );

  modport slave (
    input  startMul,
    input  A,
    input  B,
    output product,
    output busy,
    output doneMul
  );

endinterface

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param
//   Parametrised shift-add sequential multiplier, one multiplier bit per clock.
//   A start accepted in IDLE or DONE loads the operands; WIDTH iterations later the
//   full 2*WIDTH-bit product is registered and doneMul pulses for one cycle. The
//   product is held until the next result or a reset.
//
//   Build option:
//     SEQ_MUL_SIGNED_EN  when defined, A, B and product are two's complement
//                        (sign-extended adds, arithmetic shift, and the partial
//                        product for A's sign bit is subtracted). Undefined: unsigned.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   seq_multiplier_param_if slave modport (startMul, A, B, product, busy, doneMul)
//
//   Parameters:
//     WIDTH operand width, 2..64
module seq_multiplier_param #(
  parameter int unsigned WIDTH = 24
) (
  input logic                 clk,
  input logic                 rst,
  seq_multiplier_param_if.slave bus
);

  localparam int unsigned      CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;        // multiplier, consumed LSB first
  logic [WIDTH-1:0]     b_q;        // multiplicand
  logic [WIDTH:0]       acc_q;      // upper partial product plus carry/sign
  logic [WIDTH-1:0]     low_q;      // product bits already shifted out of acc
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 last_iter;
  logic [WIDTH:0]       acc_ext;
  logic [WIDTH:0]       b_ext;
  logic [WIDTH:0]       sum;        // acc after the optional add, before the shift
  logic [WIDTH:0]       acc_d;
  logic [WIDTH-1:0]     low_d;

  // One iteration of the datapath: conditional add, then shift {acc, low} right.
  always_comb begin
    last_iter = (cnt_q == LastCnt);
`ifdef SEQ_MUL_SIGNED_EN
    acc_ext = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]};
    b_ext   = {b_q[WIDTH-1], b_q};
`else
    acc_ext = {1'b0, acc_q[WIDTH-1:0]};
    b_ext   = {1'b0, b_q};
`endif
    sum = acc_q;
    if (a_q[0]) begin
`ifdef SEQ_MUL_SIGNED_EN
      // A's top bit weighs -2^(WIDTH-1), so its partial product is subtracted.
      sum = last_iter ? (acc_ext - b_ext) : (acc_ext + b_ext);
`else
      sum = acc_ext + b_ext;
`endif
    end
`ifdef SEQ_MUL_SIGNED_EN
    acc_d = {sum[WIDTH], sum[WIDTH:1]};
`else
    acc_d = {1'b0, sum[WIDTH:1]};
`endif
    low_d = {sum[0], low_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.startMul) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            acc_q   <= '0;
            low_q   <= '0;
            cnt_q   <= '0;
            state_q <= StCalc;
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          // startMul and the operand inputs are deliberately ignored here.
          acc_q <= acc_d;
          low_q <= low_d;
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            product_q <= {acc_d[WIDTH-1:0], low_d};
            state_q   <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == StCalc);
  assign bus.doneMul = (state_q == StDone);

endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param
//   Self-checking bench for seq_multiplier_param at WIDTH=8 and WIDTH=24.
//   A cycle-level behavioural model (an operation in flight is a countdown of busy
//   cycles plus the arithmetic product) is compared against both DUTs on every
//   negative clock edge; directed scenarios add literal expectations.
module tb_seq_multiplier_param;

  localparam int unsigned W8  = 8;
  localparam int unsigned W24 = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_multiplier_param_if #(.WIDTH(W8))  bus8 ();
  seq_multiplier_param_if #(.WIDTH(W24)) bus24 ();

  seq_multiplier_param #(.WIDTH(W8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  seq_multiplier_param #(.WIDTH(W24)) u_dut24 (
    .clk (clk),
    .rst (rst),
    .bus (bus24)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa, xb;
`ifdef SEQ_MUL_SIGNED_EN
    xa = {{8{a[7]}}, a};
    xb = {{8{b[7]}}, b};
`else
    xa = {8'b0, a};
    xb = {8'b0, b};
`endif
    return xa * xb;
  endfunction

  function automatic logic [47:0] mul24(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] xa, xb;
`ifdef SEQ_MUL_SIGNED_EN
    xa = {{24{a[23]}}, a};
    xb = {{24{b[23]}}, b};
`else
    xa = {24'b0, a};
    xb = {24'b0, b};
`endif
    return xa * xb;
  endfunction

  int          m8_left  = 0;   // busy cycles still to come for the op in flight
  bit          m8_done  = 1'b0;
  logic [15:0] m8_prod  = '0;
  logic [15:0] m8_pend  = '0;
  int          m24_left = 0;
  bit          m24_done = 1'b0;
  logic [47:0] m24_prod = '0;
  logic [47:0] m24_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_left  <= 0;
      m8_done  <= 1'b0;
      m8_prod  <= '0;
      m24_left <= 0;
      m24_done <= 1'b0;
      m24_prod <= '0;
    end else begin
      if (m8_left > 0) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_done <= 1'b1;
          m8_prod <= m8_pend;
        end
      end else begin
        m8_done <= 1'b0;
        if (bus8.startMul) begin
          m8_left <= int'(W8);
          m8_pend <= mul8(bus8.A, bus8.B);
        end
      end
      if (m24_left > 0) begin
        m24_left <= m24_left - 1;
        if (m24_left == 1) begin
          m24_done <= 1'b1;
          m24_prod <= m24_pend;
        end
      end else begin
        m24_done <= 1'b0;
        if (bus24.startMul) begin
          m24_left <= int'(W24);
          m24_pend <= mul24(bus24.A, bus24.B);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, compare both DUTs with the model, then step off the edge.
  task automatic tick();
    @(negedge clk);
    check("busy8",  64'(bus8.busy),     64'(m8_left > 0));
    check("done8",  64'(bus8.doneMul),  64'(m8_done));
    check("prod8",  64'(bus8.product),  64'(m8_prod));
    check("busy24", 64'(bus24.busy),    64'(m24_left > 0));
    check("done24", 64'(bus24.doneMul), 64'(m24_done));
    check("prod24", 64'(bus24.product), 64'(m24_prod));
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                     input string name);
    int cyc, busy_cnt;
    bit seen;
    bus8.startMul = 1'b1;
    bus8.A = a;
    bus8.B = b;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      bus8.startMul = 1'b0;
      bus8.A = 8'($urandom);
      bus8.B = 8'($urandom);
      if (bus8.busy) busy_cnt++;
      if (bus8.doneMul) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(cyc), 64'(9));
    check({name, "_busy"}, 64'(busy_cnt), 64'(8));
    check({name, "_prod"}, 64'(bus8.product), 64'(exp));
    tick();
    check({name, "_pulse"}, 64'(bus8.doneMul), 64'(0));
    check({name, "_hold"}, 64'(bus8.product), 64'(exp));
  endtask

  task automatic op24(input logic [23:0] a, input logic [23:0] b, input logic [47:0] exp,
                      input string name);
    int cyc, busy_cnt;
    bit seen;
    bus24.startMul = 1'b1;
    bus24.A = a;
    bus24.B = b;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      bus24.startMul = 1'b0;
      bus24.A = 24'($urandom);
      bus24.B = 24'($urandom);
      if (bus24.busy) busy_cnt++;
      if (bus24.doneMul) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(cyc), 64'(25));
    check({name, "_busy"}, 64'(busy_cnt), 64'(24));
    check({name, "_prod"}, 64'(bus24.product), 64'(exp));
    tick();
    check({name, "_pulse"}, 64'(bus24.doneMul), 64'(0));
  endtask

  function automatic logic [7:0] rnd8();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 8'h00;
    if (sel == 1) return 8'hFF;
    if (sel == 2) return 8'h80;
    return 8'($urandom);
  endfunction

  function automatic logic [23:0] rnd24();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 24'h000000;
    if (sel == 1) return 24'hFFFFFF;
    if (sel == 2) return 24'h800000;
    return 24'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cyc, t1, t2, done_cnt;

    bus8.startMul  = 1'b0;
    bus8.A         = '0;
    bus8.B         = '0;
    bus24.startMul = 1'b0;
    bus24.A        = '0;
    bus24.B        = '0;

    // Reset state.
    tick();
    check("rst_prod8", 64'(bus8.product), 64'(0));
    check("rst_busy8", 64'(bus8.busy), 64'(0));
    check("rst_done8", 64'(bus8.doneMul), 64'(0));
    check("rst_prod24", 64'(bus24.product), 64'(0));
    rst = 1'b0;
    repeat (3) tick();

    // Operand extremes.
`ifdef SEQ_MUL_SIGNED_EN
    op8(8'hFD, 8'h05, 16'hFFF1, "s_m3x5");
    op8(8'h80, 8'h80, 16'h4000, "s_min");
    op8(8'hFF, 8'hFF, 16'h0001, "s_m1xm1");
`else
    op8(8'hFF, 8'hFF, 16'hFE01, "u_max");
    op8(8'h80, 8'h80, 16'h4000, "u_80x80");
`endif
    op24(24'h000000, 24'hABCDEF, 48'h0, "zero24");
    op24(24'h000003, 24'h000007, 48'd21, "small24");

    // Back-to-back with startMul held high; operands scrambled during CALC.
    bus8.startMul = 1'b1;
    bus8.A = 8'd3;
    bus8.B = 8'd5;
    cyc = 0;
    t1 = -1;
    t2 = -1;
    while (cyc < 40 && t2 < 0) begin
      tick();
      cyc++;
      if (bus8.doneMul) begin
        if (t1 < 0) begin
          t1 = cyc;
          check("b2b_first", 64'(bus8.product), 64'd15);
          bus8.A = 8'd7;
          bus8.B = 8'd9;
        end else begin
          t2 = cyc;
          check("b2b_second", 64'(bus8.product), 64'd63);
          bus8.startMul = 1'b0;
        end
      end else if (bus8.busy) begin
        bus8.A = 8'($urandom);
        bus8.B = 8'($urandom);
      end
    end
    check("b2b_gap", 64'(t2 - t1), 64'(9));
    repeat (2) tick();

    // Abort by an asynchronous reset mid-cycle after 4 iterations.
    bus8.startMul = 1'b1;
    bus8.A = 8'hC3;
    bus8.B = 8'h5A;
    tick();
    bus8.startMul = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_prod", 64'(bus8.product), 64'(0));
    check("abort_busy", 64'(bus8.busy), 64'(0));
    check("abort_done", 64'(bus8.doneMul), 64'(0));
    tick();
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      tick();
      if (bus8.doneMul) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'(0));
    op8(8'h10, 8'h10, 16'h0100, "restart");

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus8.startMul  = ($urandom_range(0, 3) != 0);
      bus8.A         = rnd8();
      bus8.B         = rnd8();
      bus24.startMul = ($urandom_range(0, 3) != 0);
      bus24.A        = rnd24();
      bus24.B        = rnd24();
      rst            = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    bus8.startMul  = 1'b0;
    bus24.startMul = 1'b0;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
